// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem reads at the current PC, fills the IF/ID register,
// and parks a completed fetch in a one-entry skid buffer while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      imemaddr,
    input  logic [31:0]      pc_plus_4,
    output logic             imemREN,
    input  logic             ihit,
    input  logic [31:0]      imemload,
    output logic             pc_en,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [0:0] {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        skid_instr_q, skid_instr_d;
    logic [31:0]        skid_pc4_q, skid_pc4_d;

    // The address goes straight from the PC to imem; this stage only owns the handshake.
    logic addr_unused;
    assign addr_unused = ^imemaddr;

    // Next-state, IF/ID/skid updates and request/PC-enable handshake.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        imemREN      = 1'b0;
        pc_en        = 1'b0;

        if (!RST) begin
            case (state_q)
                REQ: begin
                    imemREN = 1'b1;
                    pc_en   = ihit;
                    if (flush) begin
                        instr_d = NOP_INSTR;
                        pc4_d   = 32'h0;
                        valid_d = 1'b0;
                    end else if (ihit && !stall) begin
                        instr_d = imemload;
                        pc4_d   = pc_plus_4;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (ihit) begin
                        skid_instr_d = imemload;
                        skid_pc4_d   = pc_plus_4;
                        state_d      = HOLD;
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    // Skid is full here; ihit is ignored until it drains or is squashed.
                    if (flush) begin
                        instr_d = NOP_INSTR;
                        pc4_d   = 32'h0;
                        valid_d = 1'b0;
                        pc_en   = 1'b1;
                        state_d = REQ;
                    end else if (!stall) begin
                        instr_d = skid_instr_q;
                        pc4_d   = skid_pc4_q;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= REQ;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the corner cases, then random traffic
// against a queue-based reference model; a CNT_W=4 twin checks counter wrap.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imemaddr;
    logic [31:0] pc_plus_4;
    logic        imemREN;
    logic        ihit;
    logic [31:0] imemload;
    logic        pc_en;
    logic        stall;
    logic        flush;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_cnt;

    logic        unused_ren4;
    logic        unused_pcen4;
    logic [31:0] unused_instr4;
    logic [31:0] unused_pc44;
    logic        unused_valid4;
    logic [3:0]  cnt4;

    fetch_stage #(.NOP_INSTR(NOP)) dut (
        .CLK(clk), .RST(rst), .imemaddr(imemaddr), .pc_plus_4(pc_plus_4),
        .imemREN(imemREN), .ihit(ihit), .imemload(imemload), .pc_en(pc_en),
        .stall(stall), .flush(flush), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .fetch_cnt(fetch_cnt)
    );

    fetch_stage #(.CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .imemaddr(imemaddr), .pc_plus_4(pc_plus_4),
        .imemREN(unused_ren4), .ihit(ihit), .imemload(imemload), .pc_en(unused_pcen4),
        .stall(stall), .flush(flush), .ifid_instr(unused_instr4), .ifid_pc4(unused_pc44),
        .ifid_valid(unused_valid4), .fetch_cnt(cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_t;

    typedef struct {
        logic        rst;
        logic        ihit;
        logic        stall;
        logic        flush;
        logic [31:0] data;
        logic        e_ren;
        logic        e_pcen;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_cnt;
    } vec_t;

    // Reference model: IF/ID contents, a queue standing in for the skid slot, delivery count.
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [31:0] m_cnt;
    fetch_t      m_skid[$];
    logic        m_last_pcen;
    logic [31:0] pc;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, ih, st, fl, input logic [31:0] d,
                       input logic er, ep, ev, input logic [31:0] ei, epc, ec);
        vec_t v;
        v = '{r, ih, st, fl, d, er, ep, ev, ei, epc, ec};
        tbl.push_back(v);
    endtask

    // One clock: drive at negedge, check handshake before the edge, registers after it.
    task automatic step(input logic r, ih, st, fl, input logic [31:0] d, input logic [31:0] tgt,
                        output logic s_ren, output logic s_pcen);
        logic   e_ren;
        logic   e_pcen;
        logic   holding;
        fetch_t f;
        @(negedge clk);
        rst = r; ihit = ih; stall = st; flush = fl; imemload = d;
        imemaddr = pc; pc_plus_4 = pc + 32'd4;
        #1;
        holding = (m_skid.size() != 0);
        e_ren   = !r && !holding;
        e_pcen  = !r && (holding ? fl : ih);
        s_ren   = imemREN;
        s_pcen  = pc_en;
        chk("imemREN", {31'b0, imemREN}, {31'b0, e_ren});
        chk("pc_en", {31'b0, pc_en}, {31'b0, e_pcen});
        @(posedge clk);
        f.instr = d;
        f.pc4   = pc + 32'd4;
        if (r) begin
            m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'h0; m_cnt = 32'h0;
            m_skid.delete();
        end else if (fl) begin
            m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'h0;
            m_skid.delete();
        end else if (holding) begin
            if (!st) begin
                f = m_skid.pop_front();
                m_valid = 1'b1; m_instr = f.instr; m_pc4 = f.pc4; m_cnt = m_cnt + 32'd1;
            end
        end else if (ih) begin
            if (st) m_skid.push_back(f);
            else begin
                m_valid = 1'b1; m_instr = f.instr; m_pc4 = f.pc4; m_cnt = m_cnt + 32'd1;
            end
        end else if (!st) begin
            m_valid = 1'b0;
        end
        m_last_pcen = e_pcen;
        if (r) pc = 32'h0;
        else if (e_pcen) pc = fl ? tgt : pc + 32'd4;
        #1;
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("fetch_cnt", fetch_cnt, m_cnt);
        chk("fetch_cnt_w4", {28'b0, cnt4}, m_cnt & 32'hF);
    endtask

    initial begin
        logic        s_ren;
        logic        s_pcen;
        logic        r, ih, st, fl, fl_pend;
        logic [31:0] tgt;

        rst = 1'b1; ihit = 1'b0; stall = 1'b0; flush = 1'b0;
        imemload = 32'h0; imemaddr = 32'h0; pc_plus_4 = 32'h4;
        pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'h0; m_cnt = 32'h0;
        m_last_pcen = 1'b0;

        // rst ihit stall flush data | ren pcen valid instr pc4 cnt
        add(1, 0, 0, 0, 32'h0,         0, 0, 0, NOP,           32'h0,  0);
        add(0, 1, 0, 0, 32'h0,         1, 1, 1, 32'h0,         32'h4,  1);
        add(0, 1, 0, 0, 32'h4,         1, 1, 1, 32'h4,         32'h8,  2);
        add(0, 1, 0, 0, 32'h8,         1, 1, 1, 32'h8,         32'hC,  3);
        add(0, 1, 0, 0, 32'hC,         1, 1, 1, 32'hC,         32'h10, 4);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 32'h0,     1, 0, 0, 32'hC,         32'h10, 4);
        add(0, 1, 0, 0, 32'hDEAD_0010, 1, 1, 1, 32'hDEAD_0010, 32'h14, 5);
        add(0, 1, 1, 0, 32'hAAAA_0001, 1, 1, 1, 32'hDEAD_0010, 32'h14, 5);
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, 0, 32'h5555_5555, 0, 0, 1, 32'hDEAD_0010, 32'h14, 5);
        add(0, 0, 0, 0, 32'h0,         0, 0, 1, 32'hAAAA_0001, 32'h18, 6);
        add(0, 0, 0, 1, 32'h0,         1, 0, 0, NOP,           32'h0,  6);
        add(0, 0, 0, 1, 32'h0,         1, 0, 0, NOP,           32'h0,  6);
        add(0, 1, 0, 1, 32'hBAD0_0000, 1, 1, 0, NOP,           32'h0,  6);
        add(0, 1, 0, 0, 32'h100,       1, 1, 1, 32'h100,       32'h104, 7);
        add(0, 1, 1, 0, 32'hCCCC_0002, 1, 1, 1, 32'h100,       32'h104, 7);
        add(0, 0, 1, 1, 32'h0,         0, 1, 0, NOP,           32'h0,  7);
        add(0, 0, 0, 0, 32'h0,         1, 0, 0, NOP,           32'h0,  7);
        add(0, 1, 1, 0, 32'hEEEE_0003, 1, 1, 0, NOP,           32'h0,  7);
        add(1, 0, 1, 0, 32'h0,         0, 0, 0, NOP,           32'h0,  0);
        add(0, 0, 0, 0, 32'h0,         1, 0, 0, NOP,           32'h0,  0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].ihit, tbl[i].stall, tbl[i].flush, tbl[i].data,
                 32'h100, s_ren, s_pcen);
            chk($sformatf("tbl%0d_ren", i), {31'b0, s_ren}, {31'b0, tbl[i].e_ren});
            chk($sformatf("tbl%0d_pcen", i), {31'b0, s_pcen}, {31'b0, tbl[i].e_pcen});
            chk($sformatf("tbl%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_instr", i), ifid_instr, tbl[i].e_instr);
            chk($sformatf("tbl%0d_pc4", i), ifid_pc4, tbl[i].e_pc4);
            chk($sformatf("tbl%0d_cnt", i), fetch_cnt, tbl[i].e_cnt);
        end

        // 17 back-to-back deliveries from reset: the 4-bit counter wraps to 1.
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, pc, 32'h0, s_ren, s_pcen);
        chk("wrap_cnt4", {28'b0, cnt4}, 32'd1);
        chk("wrap_cnt32", fetch_cnt, 32'd17);

        // Random traffic; a flush is held until the cycle that takes pc_en.
        fl_pend = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(63) == 0);
            ih = ($urandom_range(9) < 6);
            st = ($urandom_range(9) < 3);
            if (!fl_pend && $urandom_range(9) == 0) fl_pend = 1'b1;
            fl  = fl_pend && !r;
            tgt = $urandom & 32'hFFFF_FFFC;
            step(r, ih, st, fl, $urandom, tgt, s_ren, s_pcen);
            if (r || m_last_pcen) fl_pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
